// File: rtl/seq_int_div.sv
// Multi-cycle restoring integer divider, one quotient bit per clock.
// Signed/unsigned per request; flags divide-by-zero and signed overflow.
module seq_int_div #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           r_state, w_next;
    logic [CW-1:0]    r_cnt;
    logic             r_sm, r_sa, r_sb;
    logic [WIDTH-1:0] r_b, r_raw, r_q, r_p;
    logic [WIDTH-1:0] r_quo, r_rem;
    logic             r_dbz, r_ovf;

    logic             w_accept, w_last, w_ge;
    logic [WIDTH-1:0] w_a_abs, w_b_abs;
    logic [WIDTH:0]   w_p_sh;

    assign ready       = (r_state == IDLE) || (r_state == DONE);
    assign done        = (r_state == DONE);
    assign quotient    = r_quo;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;
    assign overflow    = r_ovf;

    assign w_accept = start && ready;
    assign w_last   = (r_cnt == CW'(WIDTH - 1));
    // -MIN wraps to MIN, which read as unsigned is exactly the magnitude.
    assign w_a_abs  = (signed_mode && dividend[WIDTH-1]) ? -dividend : dividend;
    assign w_b_abs  = (signed_mode && divisor[WIDTH-1])  ? -divisor  : divisor;
    assign w_p_sh   = {r_p, r_q[WIDTH-1]};
    assign w_ge     = (w_p_sh >= {1'b0, r_b});

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = CALC;
            CALC:    if (w_last) w_next = FIX;
            FIX:     w_next = DONE;
            DONE:    w_next = start ? CALC : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_sm  <= 1'b0;
            r_sa  <= 1'b0;
            r_sb  <= 1'b0;
            r_b   <= '0;
            r_raw <= '0;
            r_q   <= '0;
            r_p   <= '0;
            r_quo <= '0;
            r_rem <= '0;
            r_dbz <= 1'b0;
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_cnt <= '0;
            r_sm  <= signed_mode;
            r_sa  <= signed_mode && dividend[WIDTH-1];
            r_sb  <= signed_mode && divisor[WIDTH-1];
            r_b   <= w_b_abs;
            r_raw <= dividend;
            r_q   <= w_a_abs;
            r_p   <= '0;
        end else if (r_state == CALC) begin
            // P stays below |divisor|, so its low WIDTH bits are exact.
            r_cnt <= r_cnt + CW'(1);
            r_p   <= w_ge ? (w_p_sh[WIDTH-1:0] - r_b) : w_p_sh[WIDTH-1:0];
            r_q   <= {r_q[WIDTH-2:0], w_ge};
        end else if (r_state == FIX) begin
            if (r_b == '0) begin
                r_quo <= '1;
                r_rem <= r_raw;
                r_dbz <= 1'b1;
                r_ovf <= 1'b0;
            end else if (r_sa && r_sb && (r_raw == MIN_NEG) && (r_b == WIDTH'(1))) begin
                r_quo <= MIN_NEG;
                r_rem <= '0;
                r_dbz <= 1'b0;
                r_ovf <= 1'b1;
            end else begin
                r_quo <= (r_sm && (r_sa ^ r_sb)) ? -r_q : r_q;
                r_rem <= r_sa ? -r_p : r_p;
                r_dbz <= 1'b0;
                r_ovf <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_seq_int_div.sv
// Scoreboard bench for seq_int_div at WIDTH=8 (directed + random) and WIDTH=16 (random).
module tb_seq_int_div;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        st8, sm8, rdy8, dn8, dz8, ov8;
    logic [7:0]  a8, b8, q8o, r8o;
    logic        st16, sm16, rdy16, dn16, dz16, ov16;
    logic [15:0] a16, b16, q16o, r16o;

    seq_int_div #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(st8), .signed_mode(sm8),
        .dividend(a8), .divisor(b8), .ready(rdy8), .done(dn8),
        .quotient(q8o), .remainder(r8o), .div_by_zero(dz8), .overflow(ov8));

    seq_int_div #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .start(st16), .signed_mode(sm16),
        .dividend(a16), .divisor(b16), .ready(rdy16), .done(dn16),
        .quotient(q16o), .remainder(r16o), .div_by_zero(dz16), .overflow(ov16));

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
        logic        ovf;
        int          acc;
    } exp_t;

    exp_t sb8[$];
    exp_t sb16[$];
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int ndone8 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // Reference: native signed division truncates toward zero, % follows dividend sign.
    function automatic exp_t model(input int w, input logic sm, input logic [15:0] a,
                                   input logic [15:0] b, input int acc);
        exp_t e;
        longint mask, half, sa, sb;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        sa = longint'(a) & mask;
        sb = longint'(b) & mask;
        if (sm && sa >= half) sa = sa - (mask + 1);
        if (sm && sb >= half) sb = sb - (mask + 1);
        e.acc = acc; e.dbz = 1'b0; e.ovf = 1'b0;
        if (sb == 0) begin
            e.q = 16'(mask); e.r = 16'(longint'(a) & mask); e.dbz = 1'b1;
        end else if (sm && sa == -half && sb == -1) begin
            e.q = 16'(half); e.r = 16'h0; e.ovf = 1'b1;
        end else begin
            e.q = 16'((sa / sb) & mask); e.r = 16'((sa % sb) & mask);
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && dn8) begin : mon8
            exp_t e;
            ndone8++;
            if (sb8.size() == 0) begin
                checks++; errors++;
                $display("FAIL done8_unexpected got q=%0h want no done", q8o);
            end else begin
                e = sb8.pop_front();
                chk("q8", longint'(q8o), longint'(e.q));
                chk("r8", longint'(r8o), longint'(e.r));
                chk("dbz8", longint'(dz8), longint'(e.dbz));
                chk("ovf8", longint'(ov8), longint'(e.ovf));
                chk("lat8", longint'(cyc - e.acc), 10);
                chk("rdy8_in_done", longint'(rdy8), 1);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && dn16) begin : mon16
            exp_t e;
            if (sb16.size() == 0) begin
                checks++; errors++;
                $display("FAIL done16_unexpected got q=%0h want no done", q16o);
            end else begin
                e = sb16.pop_front();
                chk("q16", longint'(q16o), longint'(e.q));
                chk("r16", longint'(r16o), longint'(e.r));
                chk("dbz16", longint'(dz16), longint'(e.dbz));
                chk("ovf16", longint'(ov16), longint'(e.ovf));
                chk("lat16", longint'(cyc - e.acc), 18);
            end
        end
    end

    // Called on a negedge; returns on the negedge after the accept edge.
    task automatic issue8(input logic sm, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eq, input logic [7:0] er,
                          input logic edz, input logic eov);
        exp_t e;
        int n = 0;
        while (!rdy8 && n < 100) begin @(negedge clk); n++; end
        if (!rdy8) begin
            checks++; errors++;
            $display("FAIL ready8_timeout got=0 want=1");
        end
        st8 = 1'b1; sm8 = sm; a8 = a; b8 = b;
        e.q = {8'h0, eq}; e.r = {8'h0, er}; e.dbz = edz; e.ovf = eov; e.acc = cyc;
        sb8.push_back(e);
        @(negedge clk);
        st8 = 1'b0;
    endtask

    task automatic issue16(input logic sm, input logic [15:0] a, input logic [15:0] b);
        int n = 0;
        while (!rdy16 && n < 100) begin @(negedge clk); n++; end
        if (!rdy16) begin
            checks++; errors++;
            $display("FAIL ready16_timeout got=0 want=1");
        end
        st16 = 1'b1; sm16 = sm; a16 = a; b16 = b;
        sb16.push_back(model(16, sm, a, b, cyc));
        @(negedge clk);
        st16 = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb8.size() != 0 || sb16.size() != 0) && n < 200) begin
            @(negedge clk); n++;
        end
        if (sb8.size() != 0 || sb16.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout got=%0d want=0 pending", sb8.size() + sb16.size());
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int n0;
        exp_t e;
        logic sm;
        logic [7:0] ra, rb;
        logic [15:0] wa, wb;

        rst = 1'b1;
        st8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
        st16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", longint'(rdy8), 1);
        chk("rst_done", longint'(dn8), 0);
        chk("rst_q", longint'(q8o), 0);
        chk("rst_r", longint'(r8o), 0);
        chk("rst_flags", longint'({dz8, ov8}), 0);
        chk("rst_ready16", longint'(rdy16), 1);
        rst = 1'b0;
        @(negedge clk);

        // Directed, hand-computed; consecutive issues also exercise accept-in-DONE.
        issue8(1'b0, 8'd200, 8'd7,  8'h1C, 8'h04, 1'b0, 1'b0);
        issue8(1'b1, 8'h9C,  8'd7,  8'hF2, 8'hFE, 1'b0, 1'b0);
        chk("persist_q", longint'(q8o), 8'h1C);
        chk("persist_r", longint'(r8o), 8'h04);
        repeat (5) @(negedge clk);
        chk("persist_q_late", longint'(q8o), 8'h1C);
        issue8(1'b1, 8'h64,  8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0);
        issue8(1'b1, 8'h80,  8'h03, 8'hD6, 8'hFE, 1'b0, 1'b0);
        issue8(1'b1, 8'h80,  8'hFF, 8'h80, 8'h00, 1'b0, 1'b1);
        issue8(1'b0, 8'h80,  8'hFF, 8'h00, 8'h80, 1'b0, 1'b0);
        issue8(1'b0, 8'h05,  8'h00, 8'hFF, 8'h05, 1'b1, 1'b0);
        issue8(1'b1, 8'h05,  8'h00, 8'hFF, 8'h05, 1'b1, 1'b0);
        issue8(1'b1, 8'hFB,  8'h00, 8'hFF, 8'hFB, 1'b1, 1'b0);

        // start pulsed mid-CALC must be ignored.
        issue8(1'b0, 8'd9, 8'd3, 8'h03, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        chk("ready_in_calc", longint'(rdy8), 0);
        st8 = 1'b1; a8 = 8'hFF; b8 = 8'h01;
        @(negedge clk);
        st8 = 1'b0;
        drain();

        // Reset during CALC aborts with no done.
        n0 = ndone8;
        st8 = 1'b1; sm8 = 1'b0; a8 = 8'd200; b8 = 8'd7;
        @(negedge clk);
        st8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", longint'(rdy8), 1);
        chk("abort_done", longint'(dn8), 0);
        chk("abort_q", longint'(q8o), 0);
        chk("abort_flags", longint'({dz8, ov8}), 0);
        repeat (15) @(negedge clk);
        chk("abort_no_done", longint'(ndone8), longint'(n0));

        for (int i = 0; i < 30; i++) begin
            sm = 1'($urandom);
            ra = 8'($urandom);
            rb = (i % 10 == 0) ? 8'h00 : 8'($urandom);
            e = model(8, sm, {8'h0, ra}, {8'h0, rb}, 0);
            issue8(sm, ra, rb, e.q[7:0], e.r[7:0], e.dbz, e.ovf);
        end

        issue16(1'b1, 16'h8000, 16'hFFFF);
        issue16(1'b0, 16'hFFFF, 16'h0000);
        for (int i = 0; i < 30; i++) begin
            wa = 16'($urandom);
            wb = (i % 3 == 0) ? 16'($urandom_range(1, 300)) : 16'($urandom);
            issue16(1'($urandom), wa, wb);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
